// File: rtl/legv8_mem_pkg.sv
// Shared types for the LEGv8 MEM stage: memory op encoding, FSM state encoding
// and access-size helpers.
package legv8_mem_pkg;

  localparam int MEM_DW = 64;

  typedef enum logic [2:0] {
    LDUR   = 3'd0,
    LDURB  = 3'd1,
    LDURH  = 3'd2,
    LDURSW = 3'd3,
    STUR   = 3'd4,
    STURB  = 3'd5,
    STURH  = 3'd6,
    STURW  = 3'd7
  } mem_op_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RMW_WR = 2'd2
  } state_t;

  function automatic logic is_store(input mem_op_t op);
    return op[2];
  endfunction

  function automatic logic [3:0] size_bytes(input mem_op_t op);
    case (op)
      LDURB, STURB:  size_bytes = 4'd1;
      LDURH, STURH:  size_bytes = 4'd2;
      LDURSW, STURW: size_bytes = 4'd4;
      default:       size_bytes = 4'd8;
    endcase
  endfunction

  function automatic logic misaligned(input mem_op_t op, input logic [2:0] addr_lo);
    return (({1'b0, addr_lo} & (size_bytes(op) - 4'd1)) != 4'd0);
  endfunction

endpackage

// File: rtl/mem_lane_merge.sv
// Big-endian lane handling: load extract/extend from the MSBs of a doubleword and
// sub-word store merge into the top bytes of a previously read doubleword.
module mem_lane_merge
  import legv8_mem_pkg::*;
(
  input  mem_op_t              op_i,
  input  logic [MEM_DW-1:0]    rdata_i,
  input  logic [MEM_DW-1:0]    wdata_i,
  input  logic [MEM_DW-1:0]    base_i,
  output logic [MEM_DW-1:0]    load_data_o,
  output logic [MEM_DW-1:0]    merge_data_o
);

  // Load extract: the addressed byte is the MSB of the doubleword.
  always_comb begin
    load_data_o = rdata_i;
    case (op_i)
      LDURB:   load_data_o = {56'd0, rdata_i[63:56]};
      LDURH:   load_data_o = {48'd0, rdata_i[63:48]};
      LDURSW:  load_data_o = {{32{rdata_i[63]}}, rdata_i[63:32]};
      default: load_data_o = rdata_i;
    endcase
  end

  // Store merge: replace the top bytes of the old doubleword with the sub-word LSBs.
  always_comb begin
    merge_data_o = wdata_i;
    case (op_i)
      STURB:   merge_data_o = {wdata_i[7:0],  base_i[55:0]};
      STURH:   merge_data_o = {wdata_i[15:0], base_i[47:0]};
      STURW:   merge_data_o = {wdata_i[31:0], base_i[31:0]};
      default: merge_data_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// LEGv8 MEM-stage controller in front of a big-endian doubleword data memory.
// Optional alignment fault checking is enabled by defining MEM_ALIGN_CHECK_EN.
module mem_access_stage
  import legv8_mem_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 64,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ex_valid,
  output logic          ex_ready,
  input  logic [2:0]    ex_op,
  input  logic [AW-1:0] ex_addr,
  input  logic [DW-1:0] ex_wdata,
  input  logic [RW-1:0] ex_rd,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          wb_valid,
  output logic          wb_we,
  output logic [RW-1:0] wb_rd,
  output logic [DW-1:0] wb_data,
  output logic          fault
);

  state_t        state_q;
  mem_op_t       op_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rmw_q;
  logic [RW-1:0] rd_q;
  logic          wb_valid_q;
  logic          wb_we_q;
  logic          fault_q;
  logic [RW-1:0] wb_rd_q;
  logic [DW-1:0] wb_data_q;

  logic          load_s;
  logic          sub_store_s;
  logic          misalign_s;
  logic          accept_s;
  logic [DW-1:0] load_data_s;
  logic [DW-1:0] merge_data_s;

  assign load_s      = ~is_store(op_q);
  assign sub_store_s = is_store(op_q) && (op_q != STUR);

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign_s = misaligned(op_q, addr_q[2:0]);
`else
  assign misalign_s = 1'b0;
`endif

  // A pending sub-word store holds EX off until its write has been issued.
  assign ex_ready = rst_n && ((state_q == IDLE) || ((state_q == ACCESS) && !sub_store_s));
  assign accept_s = ex_valid && ex_ready;

  // Strobes come straight from state so an async reset removes them immediately.
  assign mem_rd    = (state_q == ACCESS) && !misalign_s && (load_s || sub_store_s);
  assign mem_wr    = ((state_q == ACCESS) && (op_q == STUR) && !misalign_s) || (state_q == RMW_WR);
  assign mem_addr  = (mem_rd || mem_wr) ? addr_q : {AW{1'b0}};
  assign mem_wdata = !mem_wr              ? {DW{1'b0}}   :
                     (state_q == RMW_WR)  ? merge_data_s : wdata_q;

  assign wb_valid = wb_valid_q;
  assign wb_we    = wb_we_q;
  assign wb_rd    = wb_rd_q;
  assign wb_data  = wb_data_q;
  assign fault    = fault_q;

  mem_lane_merge u_lane (
    .op_i         (op_q),
    .rdata_i      (mem_rdata),
    .wdata_i      (wdata_q),
    .base_i       (rmw_q),
    .load_data_o  (load_data_s),
    .merge_data_o (merge_data_s)
  );

  // Stage FSM, request register and registered WB outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_q       <= LDUR;
      addr_q     <= {AW{1'b0}};
      wdata_q    <= {DW{1'b0}};
      rmw_q      <= {DW{1'b0}};
      rd_q       <= {RW{1'b0}};
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      fault_q    <= 1'b0;
      wb_rd_q    <= {RW{1'b0}};
      wb_data_q  <= {DW{1'b0}};
    end else begin
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      fault_q    <= 1'b0;
      if (accept_s) begin
        op_q    <= mem_op_t'(ex_op);
        addr_q  <= ex_addr;
        wdata_q <= ex_wdata;
        rd_q    <= ex_rd;
      end
      case (state_q)
        IDLE: begin
          state_q <= accept_s ? ACCESS : IDLE;
        end
        ACCESS: begin
          if (sub_store_s && !misalign_s) begin
            rmw_q   <= mem_rdata;
            state_q <= RMW_WR;
          end else begin
            wb_valid_q <= 1'b1;
            wb_we_q    <= load_s && !misalign_s;
            fault_q    <= misalign_s;
            wb_rd_q    <= rd_q;
            wb_data_q  <= (load_s && !misalign_s) ? load_data_s : {DW{1'b0}};
            state_q    <= accept_s ? ACCESS : IDLE;
          end
        end
        RMW_WR: begin
          wb_valid_q <= 1'b1;
          wb_rd_q    <= rd_q;
          wb_data_q  <= {DW{1'b0}};
          state_q    <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage with a 256-byte big-endian memory model.
module tb_mem_access_stage;
  import legv8_mem_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_ready;
  logic [2:0]  ex_op;
  logic [7:0]  ex_addr;
  logic [63:0] ex_wdata;
  logic [4:0]  ex_rd;
  logic        mem_rd;
  logic        mem_wr;
  logic [7:0]  mem_addr;
  logic [63:0] mem_wdata;
  wire  [63:0] mem_rdata;
  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        fault;

  int errors = 0;
  int checks = 0;
  int overlap_cnt = 0;

  logic [7:0]  mem [256];
  logic [63:0] rd_word;

  mem_access_stage dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op),
    .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .wb_valid(wb_valid),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    rd_word = 64'd0;
    for (int i = 0; i < 8; i++) begin
      rd_word[63-8*i -: 8] = mem[8'(mem_addr + 8'(i))];
    end
  end
  assign mem_rdata = mem_rd ? rd_word : 64'bz;

  always @(posedge clk) begin
    if (mem_wr) begin
      for (int i = 0; i < 8; i++) mem[8'(mem_addr + 8'(i))] <= mem_wdata[63-8*i -: 8];
    end
  end

  always @(negedge clk) begin
    if (mem_rd && mem_wr) overlap_cnt <= overlap_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [7:0] addr, input logic [63:0] wd, input logic [4:0] rd);
    ex_valid = 1'b1; ex_op = op; ex_addr = addr; ex_wdata = wd; ex_rd = rd;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ex_valid = 1'b0; ex_op = 3'd0; ex_addr = 8'd0; ex_wdata = 64'd0; ex_rd = 5'd0;
    for (int i = 0; i < 256; i++) begin
      if (i < 8'h68) mem[i] <= {4'(i / 8), 4'(i / 8)};
      else           mem[i] <= 8'(i);
    end
    #1;
    checks++; if (ex_ready !== 1'b0) begin errors++; $display("FAIL reset_ex_ready got=%b exp=0", ex_ready); end
    checks++; if ({mem_rd, mem_wr} !== 2'b00) begin errors++; $display("FAIL reset_strobes got=%b exp=00", {mem_rd, mem_wr}); end
    checks++; if (mem_addr !== 8'd0 || mem_wdata !== 64'd0) begin errors++; $display("FAIL reset_mem_bus got=%h/%h exp=0", mem_addr, mem_wdata); end
    checks++; if ({wb_valid, wb_we, fault, wb_rd} !== 8'd0 || wb_data !== 64'd0) begin errors++; $display("FAIL reset_wb got=%b%b%b %h %h exp=0", wb_valid, wb_we, fault, wb_rd, wb_data); end
    tick(); tick();
    rst_n = 1'b1;
    #1;
    checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got=%b exp=1", ex_ready); end
    tick();
  endtask

  task automatic test_loads();
    logic [2:0]  ops  [4] = '{3'd0, 3'd3, 3'd1, 3'd2};
    logic [7:0]  adrs [4] = '{8'h08, 8'h40, 8'h50, 8'h18};
    logic [63:0] exps [4] = '{64'h1111111111111111, 64'hFFFFFFFF88888888, 64'h00000000000000AA, 64'h0000000000003333};
    for (int i = 0; i < 4; i++) begin
      drive(ops[i], adrs[i], 64'd0, 5'(i + 3));
      checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL load%0d_ready got=%b exp=1", i, ex_ready); end
      tick();
      ex_valid = 1'b0;
      checks++; if ({mem_rd, mem_wr} !== 2'b10) begin errors++; $display("FAIL load%0d_strobes got=%b exp=10", i, {mem_rd, mem_wr}); end
      checks++; if (mem_addr !== adrs[i]) begin errors++; $display("FAIL load%0d_addr got=%h exp=%h", i, mem_addr, adrs[i]); end
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL load%0d_early_wb got=%b exp=0", i, wb_valid); end
      tick();
      checks++; if ({wb_valid, wb_we, fault, mem_wr} !== 4'b1100) begin errors++; $display("FAIL load%0d_wb_flags got=%b exp=1100", i, {wb_valid, wb_we, fault, mem_wr}); end
      checks++; if (wb_data !== exps[i]) begin errors++; $display("FAIL load%0d_data got=%h exp=%h", i, wb_data, exps[i]); end
      checks++; if (wb_rd !== 5'(i + 3)) begin errors++; $display("FAIL load%0d_rd got=%0d exp=%0d", i, wb_rd, i + 3); end
      tick();
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL load%0d_pulse got=%b exp=0", i, wb_valid); end
    end
  endtask

  task automatic test_sub_store();
    drive(3'd5, 8'h10, 64'hFFFFFFFFFFFFFFEE, 5'd7);
    tick();
    ex_valid = 1'b0;
    checks++; if ({ex_ready, mem_rd, mem_wr} !== 3'b010) begin errors++; $display("FAIL sturb_read_phase got=%b exp=010", {ex_ready, mem_rd, mem_wr}); end
    tick();
    checks++; if ({ex_ready, mem_rd, mem_wr, wb_valid} !== 4'b0010) begin errors++; $display("FAIL sturb_write_phase got=%b exp=0010", {ex_ready, mem_rd, mem_wr, wb_valid}); end
    checks++; if (mem_wdata !== 64'hEE22222222222222 || mem_addr !== 8'h10) begin errors++; $display("FAIL sturb_wdata got=%h@%h exp=ee22222222222222@10", mem_wdata, mem_addr); end
    tick();
    checks++; if ({wb_valid, wb_we, ex_ready, mem_wr} !== 4'b1010) begin errors++; $display("FAIL sturb_done got=%b exp=1010", {wb_valid, wb_we, ex_ready, mem_wr}); end
    drive(3'd0, 8'h10, 64'd0, 5'd8);
    tick(); ex_valid = 1'b0; tick();
    checks++; if (wb_valid !== 1'b1 || wb_data !== 64'hEE22222222222222) begin errors++; $display("FAIL sturb_readback got=%b/%h exp=1/ee22222222222222", wb_valid, wb_data); end
    tick();
  endtask

  task automatic test_back_to_back();
    drive(3'd0, 8'h18, 64'd0, 5'd1);
    checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready0 got=%b exp=1", ex_ready); end
    tick();
    drive(3'd4, 8'h20, 64'hDEADBEEF00C0FFEE, 5'd2);
    checks++; if (ex_ready !== 1'b1 || wb_valid !== 1'b0) begin errors++; $display("FAIL b2b_ready1 got=%b%b exp=10", ex_ready, wb_valid); end
    tick();
    checks++; if ({wb_valid, wb_we} !== 2'b11 || wb_data !== 64'h3333333333333333 || wb_rd !== 5'd1) begin errors++; $display("FAIL b2b_wb0 got=%b%b %h rd=%0d exp=11 3333333333333333 rd=1", wb_valid, wb_we, wb_data, wb_rd); end
    checks++; if ({mem_rd, mem_wr} !== 2'b01 || mem_wdata !== 64'hDEADBEEF00C0FFEE) begin errors++; $display("FAIL b2b_stur got=%b %h exp=01 deadbeef00c0ffee", {mem_rd, mem_wr}, mem_wdata); end
    drive(3'd0, 8'h20, 64'd0, 5'd3);
    checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready2 got=%b exp=1", ex_ready); end
    tick();
    ex_valid = 1'b0;
    checks++; if ({wb_valid, wb_we, mem_rd} !== 3'b101) begin errors++; $display("FAIL b2b_wb1 got=%b exp=101", {wb_valid, wb_we, mem_rd}); end
    tick();
    checks++; if ({wb_valid, wb_we} !== 2'b11 || wb_data !== 64'hDEADBEEF00C0FFEE || wb_rd !== 5'd3) begin errors++; $display("FAIL b2b_wb2 got=%b%b %h rd=%0d exp=11 deadbeef00c0ffee rd=3", wb_valid, wb_we, wb_data, wb_rd); end
    tick();
  endtask

  task automatic test_reset_mid_rmw();
    drive(3'd6, 8'h30, 64'h000000000000ABCD, 5'd4);
    tick();
    ex_valid = 1'b0;
    tick();
    checks++; if (mem_wr !== 1'b1) begin errors++; $display("FAIL rmw_rst_pre got=%b exp=1", mem_wr); end
    rst_n = 1'b0;
    #1;
    checks++; if ({mem_wr, mem_rd, wb_valid} !== 3'b000) begin errors++; $display("FAIL rmw_rst_kill got=%b exp=000", {mem_wr, mem_rd, wb_valid}); end
    tick();
    checks++; if (wb_valid !== 1'b0 || mem[8'h30] !== 8'h66 || mem[8'h31] !== 8'h66) begin errors++; $display("FAIL rmw_rst_nowrite got=%b %h%h exp=0 6666", wb_valid, mem[8'h30], mem[8'h31]); end
    rst_n = 1'b1;
    tick();
    drive(3'd0, 8'h30, 64'd0, 5'd5);
    tick(); ex_valid = 1'b0; tick();
    checks++; if (wb_valid !== 1'b1 || wb_data !== 64'h6666666666666666) begin errors++; $display("FAIL rmw_rst_readback got=%b/%h exp=1/6666666666666666", wb_valid, wb_data); end
    tick();
  endtask

  task automatic test_unaligned();
    logic [7:0]  adrs [2] = '{8'h09, 8'hFC};
    logic [2:0]  ops  [2] = '{3'd2, 3'd0};
    logic [63:0] exps [2] = '{64'h0000000000001111, 64'hFCFDFEFF00000000};
    for (int i = 0; i < 2; i++) begin
      drive(ops[i], adrs[i], 64'd0, 5'd9);
      tick();
      ex_valid = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      checks++; if ({mem_rd, mem_wr} !== 2'b00) begin errors++; $display("FAIL unal%0d_no_access got=%b exp=00", i, {mem_rd, mem_wr}); end
      tick();
      checks++; if ({wb_valid, fault, wb_we} !== 3'b110 || wb_data !== 64'd0) begin errors++; $display("FAIL unal%0d_fault got=%b %h exp=110 0", i, {wb_valid, fault, wb_we}, wb_data); end
`else
      checks++; if ({mem_rd, mem_addr} !== {1'b1, adrs[i]}) begin errors++; $display("FAIL unal%0d_access got=%b@%h exp=1@%h", i, mem_rd, mem_addr, adrs[i]); end
      tick();
      checks++; if ({wb_valid, fault, wb_we} !== 3'b101 || wb_data !== exps[i]) begin errors++; $display("FAIL unal%0d_data got=%b %h exp=101 %h", i, {wb_valid, fault, wb_we}, wb_data, exps[i]); end
`endif
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_sub_store();
    test_back_to_back();
    test_reset_mid_rmw();
    test_unaligned();
    checks++; if (overlap_cnt !== 0) begin errors++; $display("FAIL rd_wr_overlap got=%0d exp=0", overlap_cnt); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
